// File: rtl/video_pkg.sv
// Shared video types: pixel word, Wishbone cycle-type codes and
// the frame reader state encoding.
package video_pkg;

   typedef logic [31:0] pixel_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic {
      RD_IDLE,
      RD_REQ
   } rd_state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone pipelined/registered bus bundle with master and slave views.
// Byte addressed, 32-bit address, DATA_BYTES-wide data.
interface wshb_if #(
   parameter int DATA_BYTES = 4
) (
   input logic clk,
   input logic rst
);

   logic [31:0]             adr;
   logic [8*DATA_BYTES-1:0] dat_ms;
   logic [8*DATA_BYTES-1:0] dat_sm;
   logic [DATA_BYTES-1:0]   sel;
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic                    ack;
   logic                    err;
   logic                    rty;
   logic [2:0]              cti;
   logic [1:0]              bte;

   modport master (
      input  clk, rst,
      output adr, dat_ms, sel, cyc, stb, we, cti, bte,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  clk, rst,
      input  adr, dat_ms, sel, cyc, stb, we, cti, bte,
      output dat_sm, ack, err, rty
   );

endinterface

// File: rtl/frame_addr_gen.sv
// Linear pixel walker: counts pixels of one frame, wraps at the end,
// restarts on request and turns the pixel index into a byte address.
module frame_addr_gen
   import video_pkg::*;
#(
   parameter int          HDISP     = 800,
   parameter int          VDISP     = 480,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          BURST_LEN = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        restart,
   output logic [31:0] adr,
   output logic        last_beat
);

   localparam int NPIX = HDISP * VDISP;
   localparam int CW   = $clog2(NPIX);
   localparam int BW   = $clog2(BURST_LEN);

   logic [CW-1:0] pix_cnt;

   // restart wins over advance: an ack seen with a frame sync lands on pixel 0
   always_ff @(posedge clk) begin
      if (rst)
         pix_cnt <= '0;
      else if (restart)
         pix_cnt <= '0;
      else if (advance)
         pix_cnt <= (pix_cnt == CW'(NPIX - 1)) ? '0 : pix_cnt + CW'(1);
   end

   assign adr       = BASE_ADDR + (32'(pix_cnt) << 2);
   assign last_beat = &pix_cnt[BW-1:0];

endmodule

// File: rtl/wshb_frame_reader.sv
// Wishbone read master streaming the framebuffer into the pixel FIFO.
// Define WSHB_BURST_EN for incrementing bursts of BURST_LEN beats.
module wshb_frame_reader
   import video_pkg::*;
#(
   parameter int          HDISP     = 800,
   parameter int          VDISP     = 480,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          BURST_LEN = 8
) (
   input  logic   clk,
   input  logic   rst,
   wshb_if.master wshb,
   input  logic   frame_sync,
   input  logic   fifo_wfull,
   output logic   fifo_write,
   output pixel_t fifo_wdata
);

`ifdef WSHB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   rd_state_t   state;
   rd_state_t   state_nxt;
   logic        restart_pend;
   logic        sync;
   logic        hit;
   logic        restart;
   logic        last_beat;
   logic [31:0] adr;

   assign sync    = frame_sync | restart_pend;
   assign hit     = (state == RD_REQ) && wshb.ack;
   assign restart = sync && ((state == RD_IDLE) || hit);

   frame_addr_gen #(
      .HDISP     (HDISP),
      .VDISP     (VDISP),
      .BASE_ADDR (BASE_ADDR),
      .BURST_LEN (BURST_LEN)
   ) u_addr (
      .clk       (clk),
      .rst       (rst),
      .advance   (hit),
      .restart   (restart),
      .adr       (adr),
      .last_beat (last_beat)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= RD_IDLE;
      else
         state <= state_nxt;
   end

   // bursts only look at the FIFO level when they start
   always_comb begin
      state_nxt = state;
      unique case (state)
         RD_IDLE: begin
            if (!fifo_wfull)
               state_nxt = RD_REQ;
         end
         RD_REQ: begin
            if (hit) begin
               if (sync || (BURST ? last_beat : fifo_wfull))
                  state_nxt = RD_IDLE;
            end else if (wshb.err || wshb.rty) begin
               state_nxt = RD_IDLE;
            end
         end
         default: state_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      wshb.cyc    = (state == RD_REQ);
      wshb.stb    = (state == RD_REQ);
      wshb.adr    = adr;
      wshb.we     = 1'b0;
      wshb.sel    = 4'hF;
      wshb.bte    = 2'b00;
      wshb.dat_ms = '0;
      wshb.cti    = CTI_CLASSIC;
      if (BURST && (state == RD_REQ))
         wshb.cti = last_beat ? CTI_EOB : CTI_INCR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         restart_pend <= 1'b0;
         fifo_write   <= 1'b0;
         fifo_wdata   <= '0;
      end else begin
         if (restart)
            restart_pend <= 1'b0;
         else if (frame_sync)
            restart_pend <= 1'b1;
         fifo_write <= hit;
         if (hit)
            fifo_wdata <= wshb.dat_sm;
      end
   end

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Self-checking bench for wshb_frame_reader: directed steps plus random
// bus/FIFO/sync traffic against a pixel-index reference model.
module tb_wshb_frame_reader;
   import video_pkg::*;

   localparam int          HDISP = 4;
   localparam int          VDISP = 4;
   localparam int          NPIX  = HDISP * VDISP;
   localparam int          BLEN  = 8;
   localparam logic [31:0] BASE  = 32'h0000_0000;

`ifdef WSHB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   rst;
   logic   frame_sync;
   logic   fifo_wfull;
   logic   fifo_write;
   pixel_t fifo_wdata;

   wshb_if #(.DATA_BYTES(4)) wb (.clk(clk), .rst(rst));

   wshb_frame_reader #(
      .HDISP     (HDISP),
      .VDISP     (VDISP),
      .BASE_ADDR (BASE),
      .BURST_LEN (BLEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wshb       (wb),
      .frame_sync (frame_sync),
      .fifo_wfull (fifo_wfull),
      .fifo_write (fifo_write),
      .fifo_wdata (fifo_wdata)
   );

   always #5 clk = ~clk;

   int          pass_cnt = 0;
   int          fail_cnt = 0;
   int          total    = 0;
   int          exp_pix  = 0;
   bit          pend     = 1'b0;
   bit          exp_wr   = 1'b0;
   bit          exp_cyc  = 1'b0;
   bit          cyc_known = 1'b0;
   logic [31:0] q[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock: check outputs at negedge, drive inputs, update model
   task automatic tick(input bit a, input bit e, input bit r,
                       input bit fs, input bit wf, input bit rs);
      bit          req;
      bit          do_ack;
      bit          do_err;
      bit          sync;
      bit          leave;
      logic [31:0] d;
      logic [2:0]  cti_exp;
      req = wb.cyc && wb.stb;
      if (cyc_known) begin
         chk("cyc", 32'(wb.cyc), 32'(exp_cyc));
         chk("stb", 32'(wb.stb), 32'(exp_cyc));
      end
      if (req) begin
         chk("adr", wb.adr, BASE + 32'(exp_pix * 4));
         chk("sel_we", {27'd0, wb.sel, wb.we}, 32'h1E);
         cti_exp = !BURST ? 3'b000 :
                   ((exp_pix % BLEN) == BLEN - 1) ? 3'b111 : 3'b010;
         chk("cti", 32'(wb.cti), 32'(cti_exp));
      end
      do_ack = req && a;
      do_err = req && !a && (e || r);
      d = $urandom;
      wb.ack     = do_ack;
      wb.err     = do_err && e;
      wb.rty     = do_err && !e;
      wb.dat_sm  = d;
      frame_sync = fs;
      fifo_wfull = wf;
      rst        = rs;
      @(posedge clk);
      if (rs) begin
         exp_pix = 0;
         pend    = 1'b0;
         exp_wr  = 1'b0;
         exp_cyc = 1'b0;
         q.delete();
      end else begin
         sync   = fs || pend;
         exp_wr = do_ack;
         if (do_ack) begin
            q.push_back(d);
            leave = sync ||
                    (BURST ? ((exp_pix % BLEN) == BLEN - 1) : wf);
            if (sync) begin
               exp_pix = 0;
               pend    = 1'b0;
            end else begin
               exp_pix = (exp_pix + 1) % NPIX;
            end
            exp_cyc = !leave;
         end else if (do_err) begin
            if (sync) begin
               exp_pix = 0;
               pend    = 1'b0;
            end
            exp_cyc = 1'b0;
         end else if (req) begin
            if (fs) pend = 1'b1;
            exp_cyc = 1'b1;
         end else begin
            if (sync) begin
               exp_pix = 0;
               pend    = 1'b0;
            end
            exp_cyc = !wf;
         end
      end
      cyc_known = 1'b1;
      @(negedge clk);
      chk("fifo_write", 32'(fifo_write), 32'(exp_wr));
      if (exp_wr && q.size() > 0)
         chk("fifo_wdata", fifo_wdata, q.pop_front());
   endtask

   task automatic run_until(input logic [31:0] target);
      int n;
      n = 0;
      while (!(wb.cyc && wb.adr == target) && n < 200) begin
         tick(1, 0, 0, 0, 0, 0);
         n++;
      end
      if (n >= 200)
         chk("reach_adr", wb.adr, target);
   endtask

   initial begin
      rst        = 1'b1;
      frame_sync = 1'b0;
      fifo_wfull = 1'b0;
      wb.ack     = 1'b0;
      wb.err     = 1'b0;
      wb.rty     = 1'b0;
      wb.dat_sm  = '0;
      @(negedge clk);
      repeat (3) tick(0, 0, 0, 0, 0, 1);

      chk("rst_cyc", 32'(wb.cyc), 32'd0);
      chk("rst_adr", wb.adr, BASE);
      chk("rst_cti", 32'(wb.cti), 32'd0);
      chk("rst_wdata", fifo_wdata, 32'd0);

      // zero-wait streaming across two frame wraps
      repeat (40) tick(1, 0, 0, 0, 0, 0);

      // FIFO almost full for ten cycles, then resume
      repeat (10) tick(1, 0, 0, 0, 1, 0);
      repeat (12) tick(1, 0, 0, 0, 0, 0);

      // bus error on 0x10, then retry
      run_until(32'h10);
      tick(0, 1, 0, 0, 0, 0);
      repeat (6) tick(1, 0, 0, 0, 0, 0);

      // retry response with wait states
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0);
      repeat (4) tick(1, 0, 0, 0, 0, 0);

      // frame sync coinciding with the ack at 0x24
      run_until(32'h24);
      tick(1, 0, 0, 1, 0, 0);
      repeat (6) tick(1, 0, 0, 0, 0, 0);

      // frame sync while idle
      repeat (3) tick(1, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 1, 1, 0);
      repeat (5) tick(1, 0, 0, 0, 0, 0);

      // frame sync during a wait state, completed by the next ack
      run_until(32'h14);
      tick(0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      repeat (4) tick(1, 0, 0, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         int p;
         p = $urandom_range(0, 99);
         tick(p < 60, p >= 60 && p < 65, p >= 65 && p < 70,
              $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 15, 1'b0);
      end

      // reset in the middle of a transfer with an in-flight ack
      run_until(32'h8);
      tick(1, 0, 0, 0, 0, 1);
      chk("midrst_adr", wb.adr, BASE);
      repeat (20) tick(1, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
